// File: rtl/tank_move_ctrl_if.sv
// Per-tank control/status bundle between the frame logic and one tank_move_ctrl.
// Master drives frame timing, keys and collisions; slave returns the tank pose.
interface tank_move_ctrl_if;
    logic        startOfFrame;
    logic        collision;
    logic [3:0]  inputKeyPressed;
    logic        enable;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic [1:0]  direction;
    logic        moving;
    logic        blocked;

    modport master (
        output startOfFrame, collision, inputKeyPressed, enable,
        input  topLeftX, topLeftY, direction, moving, blocked
    );

    modport slave (
        input  startOfFrame, collision, inputKeyPressed, enable,
        output topLeftX, topLeftY, direction, moving, blocked
    );
endinterface

// File: rtl/tank_move_ctrl.sv
// BattleCity tank mover: single-axis fixed-point motion with turn snapping,
// playfield clamping and collision rollback that blocks until the player turns.
module tank_move_ctrl #(
    parameter int INITIAL_X   = 280,
    parameter int INITIAL_Y   = 185,
    parameter int INITIAL_DIR = 0,
    parameter int SPEED       = 20,
    parameter int FRAC_BITS   = 6,
    parameter int OBJ_WIDTH   = 32,
    parameter int OBJ_HEIGHT  = 32,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 639,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 479,
    parameter int GRID_BITS   = 3
) (
    input logic             clk,
    input logic             resetN,
    tank_move_ctrl_if.slave bus
);

    localparam int W    = 11 + FRAC_BITS + 1;
    localparam int HALF = (1 << GRID_BITS) >> 1;

    typedef logic signed [W-1:0] fix_t;
    typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_t;
    typedef enum logic [1:0] {ST_IDLE, ST_MOVING, ST_BLOCKED} state_t;

    localparam fix_t X_LO   = fix_t'(X_MIN << FRAC_BITS);
    localparam fix_t X_HI   = fix_t'((X_MAX - OBJ_WIDTH + 1) << FRAC_BITS);
    localparam fix_t Y_LO   = fix_t'(Y_MIN << FRAC_BITS);
    localparam fix_t Y_HI   = fix_t'((Y_MAX - OBJ_HEIGHT + 1) << FRAC_BITS);
    localparam fix_t X_INIT = fix_t'(INITIAL_X << FRAC_BITS);
    localparam fix_t Y_INIT = fix_t'(INITIAL_Y << FRAC_BITS);
    localparam fix_t STEP   = fix_t'(SPEED);
    localparam dir_t D_INIT = dir_t'(2'(INITIAL_DIR));

    function automatic fix_t clamp(input fix_t v, input fix_t lo, input fix_t hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

    // Round the integer pixel part to the nearest grid line (half up), drop the fraction.
    function automatic fix_t snap(input fix_t v);
        fix_t ip;
        if (GRID_BITS == 0) return v;
        ip = (v >>> FRAC_BITS) + fix_t'(HALF);
        ip = (ip >>> GRID_BITS) <<< GRID_BITS;
        return ip <<< FRAC_BITS;
    endfunction

    state_t state, nx_state;
    dir_t   dir, nx_dir, bdir, nx_bdir, want_dir;
    fix_t   pos_x, pos_y, prev_x, prev_y;
    fix_t   nx_x, nx_y, nx_px, nx_py, snap_x, snap_y;
    logic   moving_q, nx_moving, coll_latch;
    logic   cur_held, want_valid, turn;

    wire [3:0] keys = bus.inputKeyPressed;

    // Keep the current heading while its key is held; otherwise fixed priority.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        cur_held = 1'b0;
        case (dir)
            DIR_UP:    cur_held = keys[1];
            DIR_DOWN:  cur_held = keys[0];
            DIR_LEFT:  cur_held = keys[2];
            DIR_RIGHT: cur_held = keys[3];
            default:   cur_held = 1'b0;
        endcase
        want_valid = |keys;
        want_dir   = dir;
        if (!cur_held) begin
            if (keys[1])      want_dir = DIR_UP;
            else if (keys[0]) want_dir = DIR_DOWN;
            else if (keys[2]) want_dir = DIR_LEFT;
            else if (keys[3]) want_dir = DIR_RIGHT;
        end
    end

    always_comb begin
        nx_state  = state;
        nx_dir    = dir;
        nx_bdir   = bdir;
        nx_x      = pos_x;
        nx_y      = pos_y;
        nx_px     = prev_x;
        nx_py     = prev_y;
        nx_moving = moving_q;
        snap_x    = pos_x;
        snap_y    = pos_y;
        turn      = (want_dir[1] != dir[1]);

        if ((coll_latch || bus.collision) && state == ST_MOVING) begin
            nx_x      = prev_x;
            nx_y      = prev_y;
            nx_state  = ST_BLOCKED;
            nx_bdir   = dir;
            nx_moving = 1'b0;
        end else if (!bus.enable) begin
            nx_moving = 1'b0;
        end else if (!want_valid) begin
            nx_state  = ST_IDLE;
            nx_moving = 1'b0;
        end else if (state == ST_BLOCKED && want_dir == bdir) begin
            nx_moving = 1'b0;
        end else begin
            // A turn re-aligns the coordinate we stop moving along onto the grid.
            if (turn) begin
                if (want_dir[1]) snap_y = clamp(snap(pos_y), Y_LO, Y_HI);
                else             snap_x = clamp(snap(pos_x), X_LO, X_HI);
            end
            nx_px = snap_x;
            nx_py = snap_y;
            nx_x  = snap_x;
            nx_y  = snap_y;
            case (want_dir)
                DIR_UP:    nx_y = clamp(snap_y - STEP, Y_LO, Y_HI);
                DIR_DOWN:  nx_y = clamp(snap_y + STEP, Y_LO, Y_HI);
                DIR_LEFT:  nx_x = clamp(snap_x - STEP, X_LO, X_HI);
                DIR_RIGHT: nx_x = clamp(snap_x + STEP, X_LO, X_HI);
                default:   nx_x = snap_x;
            endcase
            nx_dir    = want_dir;
            nx_state  = ST_MOVING;
            nx_moving = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)               state <= ST_IDLE;
        else if (bus.startOfFrame) state <= nx_state;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pos_x      <= X_INIT;
            pos_y      <= Y_INIT;
            prev_x     <= X_INIT;
            prev_y     <= Y_INIT;
            dir        <= D_INIT;
            bdir       <= D_INIT;
            moving_q   <= 1'b0;
            coll_latch <= 1'b0;
        end else if (bus.startOfFrame) begin
            pos_x      <= nx_x;
            pos_y      <= nx_y;
            prev_x     <= nx_px;
            prev_y     <= nx_py;
            dir        <= nx_dir;
            bdir       <= nx_bdir;
            moving_q   <= nx_moving;
            coll_latch <= 1'b0;
        end else if (bus.collision) begin
            coll_latch <= 1'b1;
        end
    end

    assign bus.topLeftX  = pos_x[FRAC_BITS +: 11];
    assign bus.topLeftY  = pos_y[FRAC_BITS +: 11];
    assign bus.direction = dir;
    assign bus.moving    = moving_q;
    assign bus.blocked   = (state == ST_BLOCKED);

endmodule

// File: doc/tank_move_ctrl.md
Name: tank_move_ctrl

Overview:
- Parametrised successor to the player-object mover; drives the top-left position of one BattleCity tank from the four direction keys.
- Adds single-axis motion with a facing direction, grid snapping on turns, and playfield clamping.
- Adds collision rollback: the last step is undone and motion is blocked until the player changes direction.
- One instance per tank. Outputs feed the tank bitmap/drawing block and the collision detector.

Parameters:
INITIAL_X, 280, reset top-left X in pixels
INITIAL_Y, 185, reset top-left Y in pixels
INITIAL_DIR, 0, reset facing (0 up, 1 down, 2 left, 3 right)
SPEED, 20, step per frame in fractional units (1/2^FRAC_BITS px)
FRAC_BITS, 6, fixed-point fraction bits
OBJ_WIDTH, 32, object width in pixels
OBJ_HEIGHT, 32, object height in pixels
X_MIN, 0, leftmost legal pixel column
X_MAX, 639, rightmost legal pixel column
Y_MIN, 0, top legal pixel row
Y_MAX, 479, bottom legal pixel row
GRID_BITS, 3, snap grid is 2^GRID_BITS px; 0 disables snapping

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-clock pulse per video frame
collision  in  1  level/pulse from the collision detector for this tank
inputKeyPressed  in  4  bit0 down, bit1 up, bit2 left, bit3 right
enable  in  1  0 freezes motion (frozen tank still latches collisions)
topLeftX  out  11  top-left X in integer pixels
topLeftY  out  11  top-left Y in integer pixels
direction  out  2  facing, same encoding as INITIAL_DIR
moving  out  1  1 when a step was taken in the last frame
blocked  out  1  1 while in the BLOCKED state

Behaviour:
- Positions are held internally as signed fixed point, 11+FRAC_BITS+1 bits. Outputs are the integer part (position >> FRAC_BITS), truncated to 11 bits.
- Reset values:
  - position = INITIAL_X/Y << FRAC_BITS; prev_pos = the same value.
  - direction = INITIAL_DIR; state = IDLE.
  - moving = 0; blocked = 0; coll_latch = 0.
- Collision latch:
  - coll_latch is set on any clock with collision=1.
  - A collision in the same cycle as startOfFrame counts toward that frame's evaluation.
  - coll_latch is cleared at every startOfFrame edge.
- All other state updates only on a clock edge with startOfFrame=1. New outputs are visible after that edge (latency 1 clk from the pulse).
- Desired direction (want) from keys:
  - If the current direction's key is still held, want = current direction.
  - Otherwise the highest-priority pressed key wins: up > down > left > right.
  - No keys pressed: want = none.
- States: IDLE, MOVING, BLOCKED. Per-frame evaluation, first match wins:
  1. (coll_latch or collision) and state=MOVING: position <= prev_pos, state <= BLOCKED, blocked_dir <= direction, moving <= 0.
  2. enable=0: no position or direction change; moving <= 0; state unchanged.
  3. want=none: state <= IDLE, moving <= 0, direction holds.
  4. state=BLOCKED and want=blocked_dir: stay BLOCKED, no step, moving <= 0.
  5. Otherwise, take a step:
     - direction <= want.
     - Snap: if want is on the other axis from the old direction and GRID_BITS>0, the perpendicular coordinate is rounded to the nearest 2^GRID_BITS px multiple (half rounds up) and its fraction is zeroed.
     - prev_pos <= post-snap position.
     - position <= clamp(post-snap + ±SPEED on want's axis).
     - state <= MOVING, moving <= 1.
- Clamp bounds on the integer part:
  - X in [X_MIN, X_MAX-OBJ_WIDTH+1]; Y in [Y_MIN, Y_MAX-OBJ_HEIGHT+1].
  - On a clamp, the fraction is zeroed and the coordinate is set exactly to the bound.
  - Snap results are clamped by the same rule.
- Collision while IDLE or BLOCKED: ignored; no rollback, no state change.
- blocked = (state==BLOCKED).
- Reset mid-frame returns everything to the reset values immediately; a pending latch is lost.

Test Plan:
- Reset, no keys, 10 frames -> topLeftX=280, topLeftY=185, direction=0, moving=0, blocked=0.
- Hold right (4'b1000) for 16 frames -> X fixed point 17920+320=18240, topLeftX=285, direction=3, moving=1; Y unchanged at 185.
- From reset, hold down 3 frames -> Yfp=11900. Pulse collision mid-frame, next startOfFrame -> Yfp=11880, blocked=1. Keep holding down 5 frames -> Y stays put. Press left -> blocked=0, moves left.
- INITIAL_X=600, hold right 100 frames -> topLeftX saturates at 608, never exceeds it; X fraction is 0.
- Moving right with topLeftX=283, then press up only -> topLeftX=280 and Y steps -SPEED in the same frame. Repeat with topLeftX=284 -> 288.
- Hold up+left from IDLE -> direction=0 (priority). While holding left, release up -> direction=2 and the snap applies. Drive collision on the same cycle as startOfFrame while MOVING -> rollback happens on that frame.
